// File: rtl/phase_cache_pkg.sv
// Shared types and size helpers for the phase2 row cache.
package phase_cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    function automatic int row_beats(input int row_size, input int beat_size);
        return row_size / beat_size;
    endfunction

    function automatic int win_beats(input int win_size, input int beat_size);
        return win_size / beat_size;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module sdp_ram #(
    parameter  int DEPTH = 320,
    parameter  int WIDTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/phase_row_cache.sv
// Ping-pong row cache for phase2 rows: the scheduler stream fills one bank
// while the match tree reads search windows from the other.
//
//   state | meaning
//   IDLE  | waiting for a window request on the readable bank
//   READ  | issuing WIN_BEATS reads and draining them through the skid buffer
module phase_row_cache
    import phase_cache_pkg::*;
#(
    parameter  int ROW_SIZE   = 1280,
    parameter  int WIN_SIZE   = 128,
    parameter  int BEAT_SIZE  = 8,
    parameter  int DATA_WIDTH = 16,
    localparam int ROW_BEATS  = row_beats(ROW_SIZE, BEAT_SIZE),
    localparam int WIN_BEATS  = win_beats(WIN_SIZE, BEAT_SIZE),
    localparam int BA         = $clog2(ROW_BEATS),
    localparam int DW         = BEAT_SIZE * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    input  logic          win_req_valid,
    output logic          win_req_ready,
    input  logic [BA-1:0] win_req_beat,
    output logic [DW-1:0] win_tdata,
    output logic          win_tvalid,
    input  logic          win_tready,
    output logic          win_tlast,
    output logic          row_ready,
    input  logic          row_release,
    output logic          row_err
);

    localparam int AW = $clog2(2 * ROW_BEATS);
    localparam int PW = BA + 1;                    // read pointer may run past the row end
    localparam int CW = $clog2(WIN_BEATS + 1);

    localparam logic [BA-1:0] LAST_WR  = BA'(ROW_BEATS - 1);
    localparam logic [PW-1:0] ROW_END  = PW'(ROW_BEATS);
    localparam logic [CW-1:0] WIN_N    = CW'(WIN_BEATS);
    localparam logic [CW-1:0] WIN_LAST = CW'(WIN_BEATS - 1);
    localparam logic [AW-1:0] BANK1    = AW'(ROW_BEATS);

    logic [1:0]    full, full_nxt;
    logic          wr_bank, rd_bank;
    logic [BA-1:0] wr_cnt;
    logic          rel_pend;
    rd_state_t     state;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] issue_cnt, out_cnt;
    logic          infl, infl_zero;
    logic [DW-1:0] fifo [2];
    logic          head;
    logic [1:0]    count;

    logic          wr_fire, wr_at_end, wr_close;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          req_fire, issue, rd_in_row, ram_rd_en;
    logic [DW-1:0] ram_rdata, infl_data;
    logic          out_fire, win_done, push, pop, wr_idx, do_release;

    assign s_axis_tready = rst_n & ~full[wr_bank];
    assign wr_fire       = s_axis_tvalid & s_axis_tready;
    assign wr_at_end     = (wr_cnt == LAST_WR);
    assign wr_close      = wr_fire & (s_axis_tlast | wr_at_end);
    assign wr_addr       = (wr_bank ? BANK1 : '0) + AW'(wr_cnt);

    assign row_ready     = full[rd_bank];
    assign win_req_ready = (state == IDLE) & full[rd_bank];
    assign req_fire      = win_req_valid & win_req_ready;

    // Issue only when the skid buffer can absorb every beat already in flight.
    assign issue     = (state == READ) & (issue_cnt != WIN_N) & ((count + {1'b0, infl}) < 2'd2);
    assign rd_in_row = (rd_ptr < ROW_END);
    assign ram_rd_en = issue & rd_in_row;
    assign rd_addr   = (rd_bank ? BANK1 : '0) + AW'(rd_ptr);
    assign infl_data = infl_zero ? '0 : ram_rdata;

    assign win_tvalid = (count != 2'd0) | infl;
    assign win_tdata  = (count != 2'd0) ? fifo[head] : infl_data;
    assign win_tlast  = win_tvalid & (out_cnt == WIN_LAST);
    assign out_fire   = win_tvalid & win_tready;
    assign win_done   = out_fire & win_tlast;

    // The RAM beat bypasses the buffer when the buffer is empty and the consumer is ready.
    assign push   = infl & ~((count == 2'd0) & win_tready);
    assign pop    = (count != 2'd0) & win_tready;
    assign wr_idx = head ^ count[0];

    // A release seen during READ (or together with a request) waits for the window to finish.
    assign do_release = full[rd_bank] & (row_release | rel_pend)
                      & (((state == IDLE) & ~req_fire) | win_done);

    // Bank flags: a close and a release always touch different banks.
    always_comb begin
        full_nxt = full;
        if (wr_close)   full_nxt[wr_bank] = 1'b1;
        if (do_release) full_nxt[rd_bank] = 1'b0;
    end

    sdp_ram #(
        .DEPTH (2 * ROW_BEATS),
        .WIDTH (DW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (s_axis_tdata),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rdata)
    );

    // Write side: beat counter, bank toggle on row close, sticky length error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
            row_err <= 1'b0;
        end else if (wr_fire) begin
            if (wr_close) begin
                wr_bank <= ~wr_bank;
                wr_cnt  <= '0;
                if (s_axis_tlast != wr_at_end) row_err <= 1'b1;
            end else begin
                wr_cnt <= wr_cnt + BA'(1);
            end
        end
    end

    // Bank ownership: full flags, read bank and deferred release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full     <= 2'b00;
            rd_bank  <= 1'b0;
            rel_pend <= 1'b0;
        end else begin
            full     <= full_nxt;
            if (do_release) rd_bank <= ~rd_bank;
            rel_pend <= (rel_pend | row_release) & ~do_release & ((state == READ) | req_fire);
        end
    end

    // Read FSM: latch window start, issue reads, count delivered beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            infl      <= 1'b0;
            infl_zero <= 1'b0;
        end else begin
            infl      <= issue;
            infl_zero <= ~rd_in_row;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        rd_ptr    <= {1'b0, win_req_beat};
                        issue_cnt <= '0;
                        out_cnt   <= '0;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_ptr    <= rd_ptr + PW'(1);
                        issue_cnt <= issue_cnt + CW'(1);
                    end
                    if (out_fire) out_cnt <= out_cnt + CW'(1);
                    if (win_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid buffer occupancy and head pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= 1'b0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop) head <= ~head;
        end
    end

    // Skid buffer storage, no reset needed.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_idx] <= infl_data;
    end

endmodule
